sakebi_uart_rx: RTL and testbench



---
 rtl/sakebi_uart_rx.sv | 141 ++++++++++++++
 tb/tb_sakebi_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sakebi_uart_rx.sv
// 8N1 UART receiver feeding a FIFO write port; write/overrun/frame-error strobes land one cycle after the stop decision.
// No byte buffering: i_wr_ready is sampled only at the stop decision, otherwise the byte is dropped as an overrun.
module sakebi_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_rx,
    input  logic       i_wr_ready,
    output logic       o_wr_en,
    output logic [7:0] o_wr_data,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // The IDLE cycle that sees rx_s=0 is start-bit cycle 0, so START entry with cnt=0 is cycle 1.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hist_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s;
    logic                   bit_val;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign bit_val = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '1;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
            hist_q <= {hist_q[1:0], rx_s};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {bit_val, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!bit_val) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end else if (i_wr_ready) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = shift_q;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_data   = wr_data_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sakebi_uart_rx.sv
// Bench for sakebi_uart_rx: directed and random 8N1 frames checked against an event-queue model.
module tb_sakebi_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    // Drive edge -> SYNC flops -> T0; decision at T0+HALF+9*CPB; strobe one cycle later.
    localparam int LAT  = SYNC + CPB / 2 + 9 * CPB + 1;

    localparam logic [2:0] K_WR  = 3'b001;
    localparam logic [2:0] K_OVR = 3'b010;
    localparam logic [2:0] K_FE  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rstn;
    logic       i_rx;
    logic       i_wr_ready;
    logic       o_wr_en;
    logic [7:0] o_wr_data;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model_last;
    logic [2:0] mon_kind;

    sakebi_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (i_rstn),
        .i_rx       (i_rx),
        .i_wr_ready (i_wr_ready),
        .o_wr_en    (o_wr_en),
        .o_wr_data  (o_wr_data),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input logic v);
        i_rx = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rdy, input int glitch_bit);
        exp_t e;
        i_wr_ready = rdy;
        e.cyc  = cyc + LAT;
        e.data = b;
        e.kind = !stop ? K_FE : (rdy ? K_WR : K_OVR);
        exp_q.push_back(e);
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k == 0) ? 1'b0 : ((k == 9) ? stop : b[k-1]);
            for (int c = 0; c < CPB; c++)
                tick((k - 1 == glitch_bit && c == CPB / 2) ? ~v : v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, o_wr_en, 0);
        chk({tag, "_wr_data"}, o_wr_data, 0);
        chk({tag, "_frame_err"}, o_frame_err, 0);
        chk({tag, "_overrun"}, o_overrun, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    // Scoreboard: every strobe must match the oldest expected event in kind and cycle.
    always @(negedge clk) begin
        if (!i_rstn) begin
            model_last = 8'h00;
        end else begin
            mon_kind = {o_frame_err, o_overrun, o_wr_en};
            if (mon_kind != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, mon_kind}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_kind", {29'd0, mon_kind}, {29'd0, mon_e.kind});
                    chk("pulse_cycle", cyc, mon_e.cyc);
                    if (mon_e.kind == K_WR) model_last = mon_e.data;
                    chk("wr_data", {24'd0, o_wr_data}, {24'd0, model_last});
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                mon_e = exp_q.pop_front();
                chk("missing_pulse", 0, {29'd0, mon_e.kind});
            end
        end
    end

    initial begin
        logic [7:0] rb;
        logic       rstop;
        logic       rrdy;
        int         gap;

        i_rstn     = 1'b0;
        i_rx       = 1'b1;
        i_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        i_rstn = 1'b1;
        repeat (4) tick(1'b1);
        chk_all_zero("post_reset");

        // Single byte, write expected at T0+153.
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        repeat (8) tick(1'b1);

        // Back-to-back frames, one stop bit, no gap.
        send_frame(8'h00, 1'b1, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 1'b1, -1);
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        repeat (8) tick(1'b1);

        // False start: 4-cycle low pulse.
        repeat (4) tick(1'b0);
        chk("false_start_busy_hi", o_busy, 1);
        repeat (16) tick(1'b1);
        chk("false_start_busy_lo", o_busy, 0);

        // Single-cycle glitch mid bit 3 is voted out.
        send_frame(8'h00, 1'b1, 1'b1, 3);
        repeat (8) tick(1'b1);

        // Framing error followed by a held-low break, then a good byte.
        send_frame(8'h55, 1'b0, 1'b1, -1);
        for (int i = 0; i < 40; i++) begin
            repeat (CPB) tick(1'b0);
            if (i % 10 == 9) chk("break_busy", o_busy, 1);
        end
        repeat (6) tick(1'b1);
        chk("break_exit_busy", o_busy, 0);
        send_frame(8'h12, 1'b1, 1'b1, -1);
        repeat (8) tick(1'b1);

        // Overrun then recovery.
        send_frame(8'h77, 1'b1, 1'b0, -1);
        send_frame(8'h78, 1'b1, 1'b1, -1);
        repeat (8) tick(1'b1);

        // Random frames: data, stop-bit validity, FIFO readiness and idle gaps.
        for (int f = 0; f < 16; f++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 7) != 0);
            rrdy  = ($urandom_range(0, 3) != 0);
            send_frame(rb, rstop, rrdy, -1);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            if (!rstop && gap < 4) gap = 4;
            repeat (gap) tick(1'b1);
        end
        repeat (8) tick(1'b1);

        // Reset in the middle of data bit 4 of 0x99 aborts the frame.
        i_wr_ready = 1'b1;
        rb = 8'h99;
        repeat (CPB) tick(1'b0);
        for (int k = 0; k < 4; k++) repeat (CPB) tick(rb[k]);
        repeat (CPB / 2) tick(rb[4]);
        i_rstn = 1'b0;
        i_rx   = 1'b1;
        #1;
        chk_all_zero("mid_frame_reset");
        repeat (2) tick(1'b1);
        chk_all_zero("mid_frame_reset_hold");
        i_rstn = 1'b1;
        repeat (2 * CPB) tick(1'b1);
        send_frame(8'h42, 1'b1, 1'b1, -1);
        repeat (20) tick(1'b1);

        chk("pending_events", exp_q.size(), 0);
        chk("final_idle", o_busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
